// File: rtl/data_mem_responder_pkg.sv
// Shared request/response types for the core data-memory port and responder constants.
package data_mem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] write_data;
    logic [31:0] addr;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] read_data;
    logic        yumi;
  } mem_out_s;

  localparam logic [31:0] WRITE_RESP_DATA = 32'h0;
  localparam int          BYTE_W          = 8;
  localparam int          BYTES_PER_WORD  = 4;

endpackage

// File: rtl/data_mem_responder_resp_fifo.sv
// Response buffer: synchronous FIFO whose head is visible while not empty.
module data_mem_responder_resp_fifo #(
  parameter int width_p = 32,
  parameter int depth_p = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam logic [ptr_w_lp:0] full_cnt_lp = (ptr_w_lp + 1)'(depth_p);

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp:0]   count_q, count_d;
  logic                do_pop;

  always_comb begin
    // NOTE: every always_comb output is assigned on every path, defaults first, so no latch is inferred.
    count_d  = count_q;
    empty_o  = (count_q == '0);
    full_o   = (count_q == full_cnt_lp);
    data_o   = mem_q[rd_ptr_q];
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: this small storage is reset so the head reads zero after reset; the data RAM is deliberately not reset.
      for (int i = 0; i < depth_p; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-enabled writes, fixed-latency response pipe,
// and a credit-limited output FIFO returning responses in acceptance order.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int mem_addr_width_p = 10,
  parameter int latency_p        = 2,
  parameter int fifo_depth_p     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$bits(mem_in_s)-1:0]    to_mem_flat_i,
  output logic [$bits(mem_out_s)-1:0]   from_mem_flat_o,
  output logic                          err_o,
  output logic [$clog2(fifo_depth_p):0] outstanding_o
);

  localparam int cnt_w_lp = $clog2(fifo_depth_p) + 1;
  localparam int words_lp = 1 << mem_addr_width_p;
  localparam logic [cnt_w_lp-1:0] credits_lp = cnt_w_lp'(fifo_depth_p);

  mem_in_s  to_mem;
  mem_out_s from_mem;

  logic [31:0]                 ram [words_lp];
  logic [mem_addr_width_p-1:0] word_idx;
  logic                        bad_addr, accept, deq, pipe_out_v;
  logic [31:0]                 resp_data, fifo_head;
  logic                        fifo_full, fifo_empty;

  logic [cnt_w_lp-1:0]  outstanding_q, outstanding_d;
  logic                 err_q, err_d;
  logic [latency_p-1:0] pipe_v_q, pipe_v_d;
  logic [31:0]          pipe_data_q [latency_p];
  logic [31:0]          pipe_data_d [latency_p];

  assign to_mem          = to_mem_flat_i;
  assign from_mem_flat_o = from_mem;
  assign err_o           = err_q;
  assign outstanding_o   = outstanding_q;

  always_comb begin
    word_idx = to_mem.addr[mem_addr_width_p+1:2];
    bad_addr = (|to_mem.addr[1:0]) || (|to_mem.addr[31:mem_addr_width_p+2]);
    deq      = !fifo_empty && to_mem.yumi;
    // A response leaving this cycle frees its credit for a request arriving in the same cycle.
    accept   = reset && to_mem.valid && ((outstanding_q < credits_lp) || deq);

    if (bad_addr)        resp_data = '0;
    else if (to_mem.wen) resp_data = WRITE_RESP_DATA;
    else                 resp_data = ram[word_idx];

    outstanding_d = outstanding_q;
    if (accept && !deq)      outstanding_d = outstanding_q + 1'b1;
    else if (!accept && deq) outstanding_d = outstanding_q - 1'b1;

    err_d = err_q || (accept && bad_addr);

    pipe_v_d[0]    = accept;
    pipe_data_d[0] = accept ? resp_data : '0;
    for (int i = 1; i < latency_p; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
    pipe_out_v = pipe_v_q[latency_p-1];

    from_mem.valid     = !fifo_empty;
    from_mem.read_data = fifo_head;
    from_mem.yumi      = accept;
  end

  always_ff @(posedge clk) begin
    if (accept && to_mem.wen && !bad_addr) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (to_mem.byte_en[b])
          ram[word_idx][b*BYTE_W +: BYTE_W] <= to_mem.write_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
      pipe_v_q      <= '0;
      for (int i = 0; i < latency_p; i++) pipe_data_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      pipe_v_q      <= pipe_v_d;
      for (int i = 0; i < latency_p; i++) pipe_data_q[i] <= pipe_data_d[i];
    end
  end

  // Credits bound pipe plus buffer occupancy, so the final stage never meets a full FIFO.
  data_mem_responder_resp_fifo #(
    .width_p (32),
    .depth_p (fifo_depth_p)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pipe_out_v && (!fifo_full || deq)),
    .data_i  (pipe_data_q[latency_p-1]),
    .pop_i   (deq),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: per-cycle transaction model plus directed literal checks.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mem_in_s  to_mem;
  mem_out_s from_mem;
  logic [$bits(mem_in_s)-1:0]  to_flat;
  logic [$bits(mem_out_s)-1:0] from_flat;
  logic                        err;
  logic [$clog2(DEPTH):0]      outst;

  assign to_flat  = to_mem;
  assign from_mem = from_flat;

  always #5 clk = ~clk;

  data_mem_responder #(
    .mem_addr_width_p (AW),
    .latency_p        (LAT),
    .fifo_depth_p     (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .to_mem_flat_i   (to_flat),
    .from_mem_flat_o (from_flat),
    .err_o           (err),
    .outstanding_o   (outst)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Transaction-level model: queue of pending responses with the cycle each becomes visible.
  typedef struct {
    logic [31:0] data;
    int          ready_cyc;
  } resp_t;

  resp_t       mq[$];
  logic [31:0] mram [int];
  logic        m_err = 1'b0;
  int          cyc = 0;

  logic [31:0] got_q[$];
  int          rsp_cyc_q[$];
  int          acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    bit          mv, m_acc, m_deq, bad;
    int          idx;
    logic [31:0] d;
    if (!reset) begin
      check("rst_valid", 32'(from_mem.valid), 32'd0);
      check("rst_yumi", 32'(from_mem.yumi), 32'd0);
      check("rst_data", from_mem.read_data, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_outstanding", 32'(outst), 32'd0);
      mq.delete();
      m_err = 1'b0;
    end else begin
      mv = (mq.size() > 0) && (mq[0].ready_cyc <= cyc);
      check("valid", 32'(from_mem.valid), 32'(mv));
      if (mv) check("read_data", from_mem.read_data, mq[0].data);
      check("err", 32'(err), 32'(m_err));
      check("outstanding", 32'(outst), 32'(mq.size()));
      m_deq = mv && to_mem.yumi;
      m_acc = to_mem.valid && ((mq.size() < DEPTH) || m_deq);
      check("yumi", 32'(from_mem.yumi), 32'(m_acc));

      if (from_mem.yumi) acc_cyc_q.push_back(cyc);
      if (from_mem.valid && to_mem.yumi) begin
        got_q.push_back(from_mem.read_data);
        rsp_cyc_q.push_back(cyc);
      end

      if (m_deq) void'(mq.pop_front());
      if (m_acc) begin
        bad = (to_mem.addr[1:0] != 2'b00) || (to_mem.addr >= (32'd1 << (AW + 2)));
        idx = int'(to_mem.addr >> 2);
        d   = 32'h0;
        if (bad) begin
          m_err = 1'b1;
        end else if (to_mem.wen) begin
          logic [31:0] w;
          w = mram.exists(idx) ? mram[idx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (to_mem.byte_en[b]) w[b*8 +: 8] = to_mem.write_data[b*8 +: 8];
          mram[idx] = w;
        end else begin
          d = mram.exists(idx) ? mram[idx] : 32'h0;
        end
        // Accept edge is cyc+1; the response is visible LAT edges later.
        mq.push_back('{data: d, ready_cyc: cyc + 1 + LAT});
      end
    end
  end

  always @(negedge clk) begin
    if (reset && dut.pipe_out_v && dut.fifo_full) begin
      errors++;
      $display("FAIL overflow: push into full buffer (t=%0t)", $time);
    end
  end

  // Drivers run in the posedge+1 phase; requests are held until accepted.
  task automatic send(input bit wen, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] addr);
    int budget = 0;
    to_mem.valid      = 1'b1;
    to_mem.wen        = wen;
    to_mem.byte_en    = be;
    to_mem.write_data = wd;
    to_mem.addr       = addr;
    forever begin
      @(negedge clk);
      if (from_mem.yumi) break;
      budget++;
      if (budget > 50) begin
        fail("send_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    to_mem.valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    forever begin
      @(negedge clk);
      if (outst == 0 && !from_mem.valid) break;
      budget++;
      if (budget > 100) begin
        fail("drain_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    rsp_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, n_acc;
    to_mem      = '0;
    to_mem.yumi = 1'b1;
    reset       = 1'b0;

    // Reset state, with a request presented to show it is not accepted.
    repeat (2) @(posedge clk);
    #1;
    to_mem.valid = 1'b1;
    #1;
    check("reset_yumi_lit", 32'(from_mem.yumi), 32'd0);
    check("reset_valid_lit", 32'(from_mem.valid), 32'd0);
    check("reset_outst_lit", 32'(outst), 32'd0);
    to_mem.valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read-back.
    clear_log();
    send(1'b1, 4'b1111, 32'hDEADBEEF, 32'h10);
    send(1'b0, 4'b0000, 32'h0, 32'h10);
    drain();
    check("wr_rd_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("write_resp_zero", got_q[0], 32'h0);
      check("read_back", got_q[1], 32'hDEADBEEF);
      check("read_latency", 32'(rsp_cyc_q[1] - (acc_cyc_q[1] + 1)), 32'(LAT));
    end

    // Partial write of byte lane 1.
    clear_log();
    send(1'b1, 4'b0010, 32'h0000AA00, 32'h10);
    send(1'b0, 4'b0000, 32'h0, 32'h10);
    drain();
    if (got_q.size() == 2) check("partial_write", got_q[1], 32'hDEADAAEF);
    else check("partial_count", 32'(got_q.size()), 32'd2);

    // Back-pressure: six words to read, yumi held low.
    for (int i = 0; i < 6; i++) send(1'b1, 4'b1111, 32'h1000_0000 + 32'(i), 32'h20 + 32'(4*i));
    drain();
    clear_log();
    to_mem.yumi = 1'b0;
    k = 0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      to_mem.valid = 1'b1;
      to_mem.wen   = 1'b0;
      to_mem.addr  = 32'h20 + 32'(4*k);
      @(negedge clk);
      if (from_mem.yumi) n_acc++;
      @(posedge clk);
      #1;
      if (n_acc > k) k = n_acc;
    end
    check("bp_accept_count", 32'(n_acc), 32'd4);
    check("bp_outstanding", 32'(outst), 32'd4);
    to_mem.yumi = 1'b1;
    @(negedge clk);
    check("bp_credit_reuse", 32'(from_mem.yumi), 32'd1);
    @(posedge clk);
    #1;
    to_mem.valid = 1'b0;
    to_mem.yumi  = 1'b0;
    check("bp_outst_hold", 32'(outst), 32'd4);
    to_mem.yumi = 1'b1;
    drain();
    check("bp_resp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < got_q.size(); i++) check("bp_order", got_q[i], 32'h1000_0000 + 32'(i));

    // Misaligned and out-of-range accesses.
    clear_log();
    send(1'b0, 4'b0000, 32'h0, 32'h2);
    check("err_misaligned", 32'(err), 32'd1);
    send(1'b0, 4'b0000, 32'h0, 32'h0000_1000);
    drain();
    check("err_sticky", 32'(err), 32'd1);
    check("err_resp_count", 32'(got_q.size()), 32'd2);
    for (int i = 0; i < got_q.size(); i++) check("err_resp_zero", got_q[i], 32'h0);

    // Streaming: 16 writes then 16 reads back-to-back.
    clear_log();
    for (int i = 0; i < 16; i++) send(1'b1, 4'b1111, 32'hA5A5_0000 | 32'(i*17), 32'h100 + 32'(4*i));
    for (int i = 0; i < 16; i++) send(1'b0, 4'b0000, 32'h0, 32'h100 + 32'(4*i));
    drain();
    check("stream_count", 32'(got_q.size()), 32'd32);
    if (acc_cyc_q.size() == 32) check("stream_rate", 32'(acc_cyc_q[31] - acc_cyc_q[0]), 32'd31);
    if (got_q.size() == 32)
      for (int i = 0; i < 16; i++) check("stream_data", got_q[16+i], 32'hA5A5_0000 | 32'(i*17));

    // Asynchronous reset with three requests in flight.
    to_mem.yumi = 1'b0;
    send(1'b0, 4'b0000, 32'h0, 32'h20);
    send(1'b0, 4'b0000, 32'h0, 32'h24);
    send(1'b0, 4'b0000, 32'h0, 32'h28);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(from_mem.valid), 32'd0);
    check("async_rst_outst", 32'(outst), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b1;
    to_mem.yumi = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send(1'b0, 4'b0000, 32'h0, 32'h10);
    drain();
    if (got_q.size() == 1) check("ram_persist", got_q[0], 32'hDEADAAEF);
    else check("ram_persist_count", 32'(got_q.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
